scan_loader: RTL and testbench

//  UART-to-scan-chain writer for the CSoC test harness. Decodes ASCII commands from the UART receiver,

---
 rtl/scan_loader.sv | 205 ++++++++++++++++++++
 tb/tb_scan_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_loader.sv
// UART-driven scan-chain writer for the CSoC test harness: decodes ASCII commands, shifts
// '0'/'1' characters into the scan chain, runs or resets the CSoC and acknowledges each command.
`timescale 1ns/1ps
module scan_loader #(
    parameter int CHAIN_LEN  = 1919,
    parameter int CLK_DIV    = 4,
    parameter int RUN_TICKS  = 10,
    parameter int RST_CYCLES = 16,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       rx_data,
    input  logic             new_rx_data,
    output logic             tx_start_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_ready_i,
    output logic             csoc_clk,
    output logic             csoc_rstn,
    output logic             csoc_test_se,
    output logic             csoc_test_tm,
    output logic [7:0]       csoc_data_o,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
);

    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TK_W = (RUN_TICKS > 1) ? $clog2(RUN_TICKS + 1) : 1;
    localparam int RS_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [7:0] CH_L    = 8'h4C;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_X    = 8'h58;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_BANG = 8'h21;

    typedef enum logic [2:0] {
        IDLE, LOAD_WAIT, SHIFT_LO, SHIFT_HI, RUN_LO, RUN_HI, CRST, ACK
    } state_t;

    state_t            state_r;
    logic [PH_W-1:0]   ph_cnt_r;
    logic [TK_W-1:0]   tick_cnt_r;
    logic [RS_W-1:0]   rst_cnt_r;
    logic [7:0]        ack_byte_r;
    logic              scan_bit_r;

    logic              ph_last_s;
    logic [CNT_W-1:0]  bit_count_inc_s;
    logic [TK_W-1:0]   tick_inc_s;

    // Whitespace bytes are skipped silently in both command and load contexts.
    function automatic logic is_ws(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D) || (b == 8'h20);
    endfunction

    assign ph_last_s       = (ph_cnt_r == PH_W'(CLK_DIV - 1));
    assign bit_count_inc_s = (bit_count == {CNT_W{1'b1}}) ? bit_count : bit_count + CNT_W'(1);
    assign tick_inc_s      = tick_cnt_r + TK_W'(1);
    assign csoc_data_o     = {scan_bit_r, 7'b000_0000};

    // Command FSM with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            ph_cnt_r     <= '0;
            tick_cnt_r   <= '0;
            rst_cnt_r    <= '0;
            ack_byte_r   <= 8'h00;
            scan_bit_r   <= 1'b0;
            tx_start_o   <= 1'b0;
            tx_data_o    <= 8'h00;
            csoc_clk     <= 1'b0;
            csoc_rstn    <= 1'b0;
            csoc_test_se <= 1'b0;
            csoc_test_tm <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            bit_count    <= '0;
        end else begin
            tx_start_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    csoc_rstn <= 1'b1;
                    if (new_rx_data) begin
                        if (rx_data == CH_L) begin
                            bit_count    <= '0;
                            overrun      <= 1'b0;
                            csoc_test_se <= 1'b1;
                            csoc_test_tm <= 1'b1;
                            busy         <= 1'b1;
                            state_r      <= LOAD_WAIT;
                        end else if (rx_data == CH_R) begin
                            csoc_test_se <= 1'b0;
                            csoc_test_tm <= 1'b0;
                            tick_cnt_r   <= '0;
                            ph_cnt_r     <= '0;
                            busy         <= 1'b1;
                            state_r      <= RUN_LO;
                        end else if (rx_data == CH_X) begin
                            csoc_rstn <= 1'b0;
                            rst_cnt_r <= '0;
                            busy      <= 1'b1;
                            state_r   <= CRST;
                        end else if (is_ws(rx_data)) begin
                            state_r <= IDLE;
                        end else begin
                            ack_byte_r <= CH_BANG;
                            busy       <= 1'b1;
                            state_r    <= ACK;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (new_rx_data) begin
                        if ((rx_data == CH_0) || (rx_data == CH_1)) begin
                            scan_bit_r <= rx_data[0];
                            ph_cnt_r   <= '0;
                            state_r    <= SHIFT_LO;
                        end else if (!is_ws(rx_data)) begin
                            bit_count    <= '0;
                            csoc_test_se <= 1'b0;
                            csoc_test_tm <= 1'b0;
                            ack_byte_r   <= CH_BANG;
                            state_r      <= ACK;
                        end
                    end
                end
                SHIFT_LO, RUN_LO: begin
                    if (ph_last_s) begin
                        csoc_clk <= 1'b1;
                        ph_cnt_r <= '0;
                        state_r  <= (state_r == SHIFT_LO) ? SHIFT_HI : RUN_HI;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (ph_last_s) begin
                        csoc_clk  <= 1'b0;
                        ph_cnt_r  <= '0;
                        bit_count <= bit_count_inc_s;
                        if (bit_count_inc_s == CNT_W'(CHAIN_LEN)) begin
                            csoc_test_se <= 1'b0;
                            csoc_test_tm <= 1'b0;
                            ack_byte_r   <= CH_K;
                            state_r      <= ACK;
                        end else begin
                            state_r <= LOAD_WAIT;
                        end
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                RUN_HI: begin
                    if (ph_last_s) begin
                        csoc_clk   <= 1'b0;
                        ph_cnt_r   <= '0;
                        tick_cnt_r <= tick_inc_s;
                        if (tick_inc_s == TK_W'(RUN_TICKS)) begin
                            ack_byte_r <= CH_K;
                            state_r    <= ACK;
                        end else begin
                            state_r <= RUN_LO;
                        end
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                CRST: begin
                    if (rst_cnt_r == RS_W'(RST_CYCLES - 1)) begin
                        csoc_rstn  <= 1'b1;
                        ack_byte_r <= CH_K;
                        state_r    <= ACK;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RS_W'(1);
                    end
                end
                ACK: begin
                    if (tx_ready_i) begin
                        tx_start_o <= 1'b1;
                        tx_data_o  <= ack_byte_r;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    csoc_clk     <= 1'b0;
                    csoc_test_se <= 1'b0;
                    csoc_test_tm <= 1'b0;
                    busy         <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
            // Bytes arriving while a command is executing are dropped and flagged.
            if (new_rx_data && (state_r != IDLE) && (state_r != LOAD_WAIT)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: table of command strings with hand-computed outcomes, hand-written
// reset/handshake/overrun sequences, and random command streams against a character-level model.
`timescale 1ns/1ps
module tb_scan_loader;

    localparam int CL  = 8;
    localparam int CD  = 2;
    localparam int RT  = 10;
    localparam int RC  = 16;
    localparam int CW  = 4;
    localparam int GAP = 50;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          new_rx_data = 1'b0;
    logic          tx_start_o;
    logic [7:0]    tx_data_o;
    logic          tx_ready_i = 1'b1;
    logic          csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
    logic [7:0]    csoc_data_o;
    logic          busy, overrun;
    logic [CW-1:0] bit_count;

    scan_loader #(.CHAIN_LEN(CL), .CLK_DIV(CD), .RUN_TICKS(RT), .RST_CYCLES(RC), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
        .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o), .busy(busy),
        .overrun(overrun), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed events, collected on the falling edge.
    int         cyc = 0;
    logic       prev_clk = 1'b0;
    logic       prev_d = 1'b0;
    logic       shifted_q[$];
    logic [7:0] ack_q[$];
    int         rise_times[$];
    int         hi_lens[$];
    int         rst_lens[$];
    int         run_rises = 0;
    int         hi_run = 0;
    int         lo_rst = 0;
    int         glitches = 0;

    always @(negedge clk) begin
        cyc++;
        if (csoc_clk && !prev_clk) begin
            if (csoc_test_se) shifted_q.push_back(csoc_data_o[7]);
            else begin
                run_rises++;
                rise_times.push_back(cyc);
            end
        end
        if (csoc_clk && prev_clk && csoc_test_se && (csoc_data_o[7] != prev_d)) glitches++;
        if (csoc_clk) hi_run++;
        else if (hi_run > 0) begin
            hi_lens.push_back(hi_run);
            hi_run = 0;
        end
        if (!csoc_rstn) lo_rst++;
        else if (lo_rst > 0) begin
            rst_lens.push_back(lo_rst);
            lo_rst = 0;
        end
        if (tx_start_o) ack_q.push_back(tx_data_o);
        prev_clk = csoc_clk;
        prev_d   = csoc_data_o[7];
    end

    task automatic clr_mon();
        @(posedge clk);
        #1;
        shifted_q.delete(); ack_q.delete(); rise_times.delete(); hi_lens.delete(); rst_lens.delete();
        run_rises = 0;
        glitches  = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic string bits_str();
        string s = "";
        foreach (shifted_q[i]) s = {s, shifted_q[i] ? "1" : "0"};
        return s;
    endfunction

    function automatic int first_or(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int count_not(input int q[$], input int v);
        int n = 0;
        foreach (q[i]) if (q[i] != v) n++;
        return n;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send_paced(input logic [7:0] b);
        send_byte(b);
        repeat (GAP) @(negedge clk);
    endtask

    // Character-level reference model of the command protocol.
    int         m_load = 0;
    int         m_cnt  = 0;
    int         m_runs = 0;
    int         m_rsts = 0;
    logic       m_bits[$];
    logic [7:0] m_acks[$];

    function automatic logic ws(input logic [7:0] b);
        return (b == "\n") || (b == "\r") || (b == " ");
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (m_load != 0) begin
            if (b == "0" || b == "1") begin
                m_bits.push_back(b == "1");
                m_cnt++;
                if (m_cnt == CL) begin
                    m_acks.push_back("K");
                    m_load = 0;
                end
            end else if (!ws(b)) begin
                m_acks.push_back("!");
                m_cnt  = 0;
                m_load = 0;
            end
        end else begin
            if (b == "L") begin
                m_load = 1;
                m_cnt  = 0;
            end else if (b == "R") begin
                m_runs += RT;
                m_acks.push_back("K");
            end else if (b == "X") begin
                m_rsts++;
                m_acks.push_back("K");
            end else if (!ws(b)) m_acks.push_back("!");
        end
    endtask

    typedef struct {
        string      cmd;
        string      bits;
        logic [7:0] ack;
        int         runs;
        int         cnt;
    } vec_t;
    vec_t vecs[8];

    task automatic set_vec(input int i, input string c, input string b, input logic [7:0] a,
                           input int r, input int n);
        vecs[i].cmd = c; vecs[i].bits = b; vecs[i].ack = a; vecs[i].runs = r; vecs[i].cnt = n;
    endtask

    function automatic int out_vec();
        return int'({tx_start_o, tx_data_o, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm,
                     csoc_data_o, busy, overrun, bit_count});
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int mism;

        set_vec(0, "L10110010",     "10110010", "K", 0,  8);
        set_vec(1, "L1 \n0x",       "10",       "!", 0,  0);
        set_vec(2, "\r L00000000",  "00000000", "K", 0,  8);
        set_vec(3, "Z",             "",         "!", 0,  8);
        set_vec(4, "L111L",         "111",      "!", 0,  0);
        set_vec(5, "R",             "",         "K", RT, 0);
        set_vec(6, "X",             "",         "K", 0,  0);
        set_vec(7, " L11111111",    "11111111", "K", 0,  8);

        // Power-on reset values and csoc_rstn release on the first edge.
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("csoc_rstn_release", int'(csoc_rstn), 1);
        chk("idle_busy", int'(busy), 0);

        // Reset in the middle of a shift aborts with no acknowledge.
        clr_mon();
        send_byte("L");
        repeat (2) @(negedge clk);
        send_byte("1");
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midshift_reset_outputs", out_vec(), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("midshift_no_ack", ack_q.size(), 0);
        chk("midshift_csoc_rstn", int'(csoc_rstn), 1);

        // Table of complete commands.
        for (int v = 0; v < 8; v++) begin
            clr_mon();
            for (int c = 0; c < vecs[v].cmd.len(); c++) send_paced(vecs[v].cmd[c]);
            chk($sformatf("vec%0d_ack_count", v), ack_q.size(), 1);
            chk($sformatf("vec%0d_ack_byte", v), (ack_q.size() > 0) ? int'(ack_q[0]) : -1, int'(vecs[v].ack));
            chk_str($sformatf("vec%0d_bits", v), bits_str(), vecs[v].bits);
            chk($sformatf("vec%0d_runs", v), run_rises, vecs[v].runs);
            chk($sformatf("vec%0d_bit_count", v), int'(bit_count), vecs[v].cnt);
            chk($sformatf("vec%0d_se_tm_busy", v), int'({csoc_test_se, csoc_test_tm, busy}), 0);
            chk($sformatf("vec%0d_data_glitch", v), glitches, 0);
            chk($sformatf("vec%0d_hi_len", v), count_not(hi_lens, CD), 0);
        end

        // Run pulse spacing.
        clr_mon();
        send_paced("R");
        chk("run_pulses", run_rises, RT);
        mism = 0;
        for (int i = 1; i < rise_times.size(); i++)
            if (rise_times[i] - rise_times[i-1] != 2 * CD) mism++;
        chk("run_period", mism, 0);
        chk("run_hi_len", count_not(hi_lens, CD), 0);
        chk("run_no_shift", shifted_q.size(), 0);

        // CSoC reset with the transmitter busy.
        clr_mon();
        tx_ready_i = 1'b0;
        send_byte("X");
        repeat (50) @(negedge clk);
        chk("crst_pulses", rst_lens.size(), 1);
        chk("crst_len", first_or(rst_lens), RC);
        chk("crst_ack_held", ack_q.size(), 0);
        chk("crst_busy_held", int'(busy), 1);
        tx_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("crst_ack_count", ack_q.size(), 1);
        chk("crst_ack_byte", (ack_q.size() > 0) ? int'(ack_q[0]) : -1, int'("K"));
        chk("crst_idle", int'(busy), 0);

        // Byte injected during the high phase is dropped and flagged.
        clr_mon();
        send_byte("L");
        repeat (3) @(negedge clk);
        send_byte("1");
        @(negedge clk);
        send_byte("0");
        repeat (10) @(negedge clk);
        chk("ovr_set", int'(overrun), 1);
        chk_str("ovr_bits", bits_str(), "1");
        chk("ovr_count", int'(bit_count), 1);
        send_paced("x");
        chk("ovr_sticky", int'(overrun), 1);
        send_paced("L");
        chk("ovr_cleared", int'(overrun), 0);
        send_paced("x");

        // Random command streams against the model.
        clr_mon();
        m_load = 0; m_cnt = 0; m_runs = 0; m_rsts = 0;
        m_bits.delete(); m_acks.delete();
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 15))
                9:       b = " ";
                10:      b = "\n";
                11, 12:  b = "L";
                13:      b = "R";
                14:      b = "X";
                15:      b = "?";
                default: b = ($urandom_range(0, 1) == 1) ? "1" : "0";
            endcase
            model_byte(b);
            send_paced(b);
        end
        if (m_load != 0) begin
            model_byte("?");
            send_paced("?");
        end
        chk("rnd_ack_count", ack_q.size(), m_acks.size());
        mism = 0;
        for (int i = 0; i < ack_q.size() && i < m_acks.size(); i++) if (ack_q[i] != m_acks[i]) mism++;
        chk("rnd_ack_seq", mism, 0);
        chk("rnd_bit_total", shifted_q.size(), m_bits.size());
        mism = 0;
        for (int i = 0; i < shifted_q.size() && i < m_bits.size(); i++) if (shifted_q[i] != m_bits[i]) mism++;
        chk("rnd_bit_seq", mism, 0);
        chk("rnd_runs", run_rises, m_runs);
        chk("rnd_rsts", rst_lens.size(), m_rsts);
        chk("rnd_rst_len", count_not(rst_lens, RC), 0);
        chk("rnd_hi_len", count_not(hi_lens, CD), 0);
        chk("rnd_bit_count", int'(bit_count), m_cnt);
        chk("rnd_overrun", int'(overrun), 0);
        chk("rnd_busy", int'(busy), 0);
        chk("rnd_glitch", glitches, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
